// File: rtl/vend_dispenser.sv
// Dispense back-end: runs the product motor, waits for drop confirmation, then pays
// change one coin per hopper handshake while tracking hopper inventory and faults.
module vend_dispenser #(
  parameter int MOTOR_CYCLES = 8,
  parameter int DROP_TIMEOUT = 16,
  parameter int CNT_W        = 4,
  parameter int COIN_CAP     = 15
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  input  logic             i_cmd_vend,
  input  logic [1:0]       i_cmd_change,
  output logic             o_busy,
  output logic             o_motor_on,
  input  logic             i_drop_sense,
  output logic             o_hop_req,
  input  logic             i_hop_ack,
  input  logic             i_refill,
  output logic [CNT_W-1:0] o_coin_cnt,
  output logic             o_done,
  output logic [1:0]       o_fault
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_MOTOR     = 3'd1;
  localparam logic [2:0] S_DROP_WAIT = 3'd2;
  localparam logic [2:0] S_PAY_REQ   = 3'd3;
  localparam logic [2:0] S_PAY_GAP   = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam int TMAX  = (MOTOR_CYCLES > DROP_TIMEOUT) ? MOTOR_CYCLES : DROP_TIMEOUT;
  localparam int TMR_W = $clog2(TMAX + 1);
  localparam logic [TMR_W-1:0] MOTOR_LAST = TMR_W'(MOTOR_CYCLES - 1);
  localparam logic [TMR_W-1:0] DROP_LAST  = TMR_W'(DROP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CAP        = CNT_W'(COIN_CAP);

  logic [2:0]       r_state, w_state_next;
  logic [TMR_W-1:0] r_tmr, w_tmr_next;
  logic [1:0]       r_left, w_left_next;
  logic [CNT_W-1:0] r_coin_cnt, w_coin_next;
  logic [1:0]       r_fault, w_fault_next;
  logic             r_busy, r_motor_on, r_hop_req, r_done;
  logic             w_hop_next;

  always_comb begin
    w_state_next = r_state;
    w_tmr_next   = r_tmr;
    w_left_next  = r_left;
    w_coin_next  = r_coin_cnt;
    w_fault_next = r_fault;
    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          // Reserved change code pays nothing but is flagged as a change error.
          w_fault_next = {(i_cmd_change == 2'b11), 1'b0};
          w_left_next  = (i_cmd_change == 2'b11) ? 2'd0 : i_cmd_change;
          w_tmr_next   = '0;
          w_state_next = i_cmd_vend ? S_MOTOR : S_PAY_REQ;
        end else if (i_refill) begin
          w_coin_next = CAP;
        end
      end
      S_MOTOR: begin
        if (r_tmr == MOTOR_LAST) begin
          w_tmr_next   = '0;
          w_state_next = S_DROP_WAIT;
        end else begin
          w_tmr_next = r_tmr + 1'b1;
        end
      end
      S_DROP_WAIT: begin
        if (i_drop_sense) begin
          w_state_next = S_PAY_REQ;
        end else if (r_tmr == DROP_LAST) begin
          w_fault_next[0] = 1'b1;
          w_state_next    = S_PAY_REQ;
        end else begin
          w_tmr_next = r_tmr + 1'b1;
        end
      end
      S_PAY_REQ: begin
        if (r_left == 2'd0) begin
          w_state_next = S_DONE;
        end else if (r_coin_cnt == '0) begin
          w_fault_next[1] = 1'b1;
          w_left_next     = 2'd0;
          w_state_next    = S_DONE;
        end else if (i_hop_ack) begin
          w_coin_next  = r_coin_cnt - 1'b1;
          w_left_next  = r_left - 1'b1;
          w_state_next = S_PAY_GAP;
        end
      end
      S_PAY_GAP: w_state_next = S_PAY_REQ;
      S_DONE:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state.
  assign w_hop_next = (w_state_next == S_PAY_REQ) && (w_left_next != 2'd0) &&
                      (w_coin_next != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_tmr      <= '0;
      r_left     <= 2'd0;
      r_coin_cnt <= CAP;
      r_fault    <= 2'b00;
      r_busy     <= 1'b0;
      r_motor_on <= 1'b0;
      r_hop_req  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_tmr      <= w_tmr_next;
      r_left     <= w_left_next;
      r_coin_cnt <= w_coin_next;
      r_fault    <= w_fault_next;
      r_busy     <= (w_state_next != S_IDLE);
      r_motor_on <= (w_state_next == S_MOTOR);
      r_hop_req  <= w_hop_next;
      r_done     <= (w_state_next == S_DONE);
    end
  end

  assign o_busy     = r_busy;
  assign o_motor_on = r_motor_on;
  assign o_hop_req  = r_hop_req;
  assign o_coin_cnt = r_coin_cnt;
  assign o_done     = r_done;
  assign o_fault    = r_fault;

endmodule

// File: doc/vend_dispenser.md
# vend_dispenser

Back-end dispense controller for the vending machine: it turns a settled sale (product owed and change owed, in 5-unit coins) into physical actions. It drives the product motor with drop confirmation and runs a one-coin-per-handshake exchange with the coin hopper. It also tracks the hopper coin inventory and reports jam and shortfall faults. It sits between the coin-acceptance FSM and the motor and hopper drivers.

## Interface
- MOTOR_CYCLES, 8: cycles `motor_on` is held per vend (≥1).
- DROP_TIMEOUT, 16: max cycles to wait for `drop_sense` after the motor stops (≥1).
- CNT_W, 4: width of the coin inventory counter.
- COIN_CAP, 15: value loaded by `refill` (≤ 2^CNT_W−1).

Ports:
- Clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command strobe, sampled only when `busy`=0.
- cmd_vend  in  1  1 = dispense one product.
- cmd_change  in  2  coins owed: 00 = none, 01 = one coin, 10 = two coins, 11 = reserved.
- busy  out  1  command in progress; new commands are ignored.
- motor_on  out  1  product motor drive.
- drop_sense  in  1  product-drop sensor, active high.
- hop_req  out  1  request to eject one coin.
- hop_ack  in  1  hopper has ejected the coin.
- refill  in  1  load the inventory to COIN_CAP.
- coin_cnt  out  CNT_W  coins remaining in the hopper.
- done  out  1  one-cycle pulse when a command completes.
- fault  out  2  bit0 = product jam (drop timeout); bit1 = change error (shortfall or reserved code).

## Operation
- States: IDLE, MOTOR, DROP_WAIT, PAY_REQ, PAY_GAP, DONE.
- **IDLE.** `busy`=0.
  - On `cmd_valid`=1, latch `cmd_vend` and `cmd_change` and clear `fault` to 00.
  - Next state: MOTOR if `cmd_vend`=1, otherwise PAY_REQ.
  - `cmd_change`=11 is treated as 0 coins and sets `fault[1]`.
- **MOTOR.** `motor_on`=1 for exactly MOTOR_CYCLES cycles, then go to DROP_WAIT.
- **DROP_WAIT.** `motor_on`=0; count cycles.
  - `drop_sense`=1 → go to PAY_REQ.
  - After DROP_TIMEOUT cycles with no `drop_sense` → set `fault[0]` and go to PAY_REQ. Change is still paid after a jam.
- **PAY_REQ.** Decision order:
  - Coins left = 0 → go to DONE.
  - Else `coin_cnt`=0 → set `fault[1]`, abandon the remaining coins, go to DONE.
  - Else drive `hop_req`=1 and hold it until `hop_ack`=1. There is no timeout on `hop_ack`.
  - On the `hop_ack` cycle, decrement `coin_cnt` and coins left, then go to PAY_GAP.
- **PAY_GAP.** `hop_req`=0 for one cycle, then return to PAY_REQ. This guarantees a low gap between coin requests.
- **DONE.** `done`=1 for one cycle, then go to IDLE.
- **Inventory.**
  - `refill` acts only in IDLE with `cmd_valid`=0; it sets `coin_cnt`=COIN_CAP. A command in the same cycle wins and the refill is dropped.
  - `coin_cnt` never underflows; the PAY_REQ check prevents it.
- `fault` is sticky from the moment it is set until the next accepted command.
- `hop_ack` outside PAY_REQ and `drop_sense` outside DROP_WAIT are ignored.
- Reset at any time, including mid-vend or mid-payment, aborts the operation immediately. No `done` pulse is generated.

## Timing
- Reset values: state IDLE, `busy`=0, `motor_on`=0, `hop_req`=0, `done`=0, `fault`=00, `coin_cnt`=COIN_CAP.
- All outputs are registered.
- Command accepted at edge k:
  - `busy`=1 from cycle k+1 until the cycle after `done`.
  - For a vend, `motor_on`=1 in cycles k+1 … k+MOTOR_CYCLES.
- `drop_sense` is sampled from the first DROP_WAIT cycle. If seen in DROP_WAIT cycle j, `hop_req` (if coins are owed) rises at cycle j+1.
- Change only, with stock available: `hop_req` high at k+1. For each coin, ack at cycle a means `coin_cnt` updates at a+1, `hop_req` is low at a+1, and the next `hop_req` is at a+2.
- `done` comes one cycle after the final PAY_REQ decision. Minimum command latency (no vend, no change) is accept → `done` at k+2.

## Test plan
- Reset, then cmd vend=1 change=00 with `drop_sense` 3 cycles after the motor stops → `motor_on` high 8 cycles, `done` pulse, `fault`=00, `coin_cnt`=15.
- Cmd vend=1 change=10 with `hop_ack` one cycle after each `hop_req` → two `hop_req` pulses with a 1-cycle low gap, `coin_cnt` 15→13, `done`, `fault`=00.
- Cmd vend=1 change=01 with no `drop_sense` → after 8+16 cycles `fault[0]`=1, one coin paid, `coin_cnt`=14, `done`.
- `coin_cnt`=1 and cmd vend=0 change=10 → one coin paid, then `fault`=10, `coin_cnt`=0, `done`. A following `refill` gives `coin_cnt`=15.
- Cmd change=11 → no `hop_req`, `fault`=10, `done` at k+2. A `cmd_valid` asserted while `busy` is ignored.
- Assert `rst_n`=0 mid-payment while `hop_req`=1 → all outputs return to reset values asynchronously and `coin_cnt`=15.
